alu_sequencer: RTL

- Initiator for the 32-bit ALU. Accepts one operation request per transaction over a valid/ready handshake and drives A, B and the 5-bit opcode to the combinational ALU.
- Waits a programmable settle time, then captures the 64-bit result into an internal Z register.
- Returns Z as one 32-bit beat, or two beats (LO, then HI) for MUL/DIV, over a second valid/ready handshake.
- Also maintains the architectural HI/LO registers for MUL/DIV.

---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_sequencer_if.sv | 27 ++
 rtl/alu_sequencer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Definitions shared by the ALU and its sequencer: opcode encoding, opcode
// classification helpers and the sequencer state enumeration.
package alu_pkg;

    typedef enum logic [4:0] {
        OP_AND  = 5'd0,
        OP_OR   = 5'd1,
        OP_NOT  = 5'd2,
        OP_NEG  = 5'd3,
        OP_ADD  = 5'd4,
        OP_SUB  = 5'd5,
        OP_MUL  = 5'd6,
        OP_DIV  = 5'd7,
        OP_SHR  = 5'd8,
        OP_SHRA = 5'd9,
        OP_SHL  = 5'd10,
        OP_ROR  = 5'd11,
        OP_ROL  = 5'd12
    } opcode_e;

    localparam logic [4:0] OP_MAX_LEGAL = 5'd12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RSP_LO,
        ST_RSP_HI
    } state_e;

    function automatic logic op_is_legal(input logic [4:0] op);
        return op <= OP_MAX_LEGAL;
    endfunction

    // Wide ops return 64 significant bits (DIV: quotient in LO, remainder in HI).
    function automatic logic op_is_wide(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Request and response handshakes of the ALU sequencer. The master side
// issues requests and consumes response beats; the sequencer is the slave.
interface alu_sequencer_if;

    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_opcode;
    logic [31:0] req_a;
    logic [31:0] req_b;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_last;
    logic        rsp_err;

    modport master (
        output req_valid, req_opcode, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_last, rsp_err
    );

    modport slave (
        input  req_valid, req_opcode, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_last, rsp_err
    );

endinterface

// File: rtl/alu_sequencer.sv
// Drives one operation at a time into the combinational ALU, waits ALU_LATENCY
// edges, captures the result and returns it as one or two response beats.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned ALU_LATENCY = 1
) (
    input  logic               clock,
    input  logic               clear,
    alu_sequencer_if.slave     bus,
    output logic [31:0]        alu_a,
    output logic [31:0]        alu_b,
    output logic [4:0]         alu_opcode,
    input  logic [63:0]        alu_result,
    output logic [31:0]        hi_out,
    output logic [31:0]        lo_out,
    output logic               busy
);

    localparam logic [3:0] CNT_INIT = 4'(ALU_LATENCY - 1);

    state_e      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [4:0]  op_q, op_d;
    logic [63:0] z_q, z_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        wide;

    assign wide = op_is_wide(op_q);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d        = state_q;
        a_d            = a_q;
        b_d            = b_q;
        op_d           = op_q;
        z_d            = z_q;
        hi_d           = hi_q;
        lo_d           = lo_q;
        cnt_d          = cnt_q;
        err_d          = err_q;
        bus.req_ready  = 1'b0;
        bus.rsp_valid  = 1'b0;
        bus.rsp_data   = z_q[31:0];
        bus.rsp_last   = 1'b0;
        bus.rsp_err    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    a_d     = bus.req_a;
                    b_d     = bus.req_b;
                    op_d    = bus.req_opcode;
                    cnt_d   = CNT_INIT;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt_q == 4'd0) begin
                    // Illegal opcodes yield a zero result rather than whatever the ALU drives.
                    z_d   = op_is_legal(op_q) ? alu_result : 64'd0;
                    err_d = !op_is_legal(op_q);
                    if (wide) begin
                        lo_d = alu_result[31:0];
                        hi_d = alu_result[63:32];
                    end
                    state_d = ST_RSP_LO;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RSP_LO: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_data  = z_q[31:0];
                bus.rsp_last  = !wide;
                bus.rsp_err   = err_q;
                if (bus.rsp_ready) begin
                    state_d = wide ? ST_RSP_HI : ST_IDLE;
                end
            end
            ST_RSP_HI: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_data  = z_q[63:32];
                bus.rsp_last  = 1'b1;
                bus.rsp_err   = err_q;
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            z_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            z_q     <= z_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_opcode = op_q;
    assign hi_out     = hi_q;
    assign lo_out     = lo_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
